mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_pkg.sv | 63 ++++++
 rtl/cond_unit.sv | 47 ++++
 rtl/mc_control.sv | 145 ++++++++++++++
 tb/tb_mc_control.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle ARM-subset controller.
// Build option: MC_CONTROL_CMP_EN enables the CMP data-processing command.
package mc_pkg;

    localparam int unsigned FLAG_W  = 4;
    localparam int unsigned OP_W    = 2;
    localparam int unsigned CMD_W   = 4;
    localparam int unsigned ALUC_W  = 2;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH
    } mc_state_t;

    localparam logic [OP_W-1:0] OP_DP  = 2'b00;
    localparam logic [OP_W-1:0] OP_MEM = 2'b01;
    localparam logic [OP_W-1:0] OP_BR  = 2'b10;

    localparam logic [ALUC_W-1:0] ALU_ADD = 2'b00;
    localparam logic [ALUC_W-1:0] ALU_SUB = 2'b01;
    localparam logic [ALUC_W-1:0] ALU_AND = 2'b10;
    localparam logic [ALUC_W-1:0] ALU_ORR = 2'b11;

    localparam logic [CMD_W-1:0] CMD_ADD = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_AND = 4'b0000;
    localparam logic [CMD_W-1:0] CMD_ORR = 4'b1100;
    localparam logic [CMD_W-1:0] CMD_CMP = 4'b1010;

`ifdef MC_CONTROL_CMP_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    // Data-processing command to ALU operation; CMP subtracts, unknown codes add.
    function automatic logic [ALUC_W-1:0] alu_decode(input logic [CMD_W-1:0] cmd,
                                                     input logic            is_cmp);
        logic [ALUC_W-1:0] res;
        res = ALU_ADD;
        if (is_cmp) begin
            res = ALU_SUB;
        end else begin
            case (cmd)
                CMD_ADD: res = ALU_ADD;
                CMD_SUB: res = ALU_SUB;
                CMD_AND: res = ALU_AND;
                CMD_ORR: res = ALU_ORR;
                default: res = ALU_ADD;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/cond_unit.sv
// NZCV flag register and ARM condition-code evaluation against the stored flags.
module cond_unit (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [3:0]                 Cond,
    input  logic [mc_pkg::FLAG_W-1:0]  ALUFlags,
    input  logic                       FlagLoad,
    output logic                       CondEx
);

    logic [mc_pkg::FLAG_W-1:0] flags;
    logic n, z, c, v;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags <= '0;
        end else if (FlagLoad) begin
            flags <= ALUFlags;
        end
    end

    assign {n, z, c, v} = flags;

    // Evaluated on the registered flags, so a same-cycle load sees old values.
    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            4'b0000: CondEx = z;
            4'b0001: CondEx = ~z;
            4'b0010: CondEx = c;
            4'b0011: CondEx = ~c;
            4'b0100: CondEx = n;
            4'b0101: CondEx = ~n;
            4'b0110: CondEx = v;
            4'b0111: CondEx = ~v;
            4'b1000: CondEx = c & ~z;
            4'b1001: CondEx = ~c | z;
            4'b1010: CondEx = (n == v);
            4'b1011: CondEx = (n != v);
            4'b1100: CondEx = ~z & (n == v);
            4'b1101: CondEx = z | (n != v);
            4'b1110: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Moore-style multicycle controller: state sequencing, datapath selects, conditional write gating.
// Build option: MC_CONTROL_CMP_EN (see mc_pkg) adds CMP handling.
module mc_control
    import mc_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [31:12]         Instr,
    input  logic [FLAG_W-1:0]    ALUFlags,
    output logic                 PCWrite,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic                 IRWrite,
    output logic                 AdrSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           RegSrc,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ImmSrc,
    output logic [ALUC_W-1:0]    ALUControl
);

    mc_state_t state, state_nxt;

    logic [3:0]      cond;
    logic [OP_W-1:0] op;
    logic [5:0]      funct;
    logic [3:0]      rd;
    logic            unused_rn;

    logic next_pc, reg_w, mem_w, branch, alu_op;
    logic ir_write, adr_src, alu_src_a;
    logic [1:0] alu_src_b, result_src;
    logic cond_ex, flag_load, is_cmp;

    assign cond      = Instr[31:28];
    assign op        = Instr[27:26];
    assign funct     = Instr[25:20];
    assign rd        = Instr[15:12];
    assign unused_rn = ^Instr[19:16];

    assign is_cmp = CMP_EN && (op == OP_DP) && (funct[4:1] == CMD_CMP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state Moore outputs; anything not set stays 0.
    always_comb begin
        state_nxt  = FETCH;
        next_pc    = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        alu_op     = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        case (state)
            FETCH: begin
                state_nxt  = DECODE;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = 1'b1;
                next_pc    = 1'b1;
            end
            DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                case (op)
                    OP_MEM:  state_nxt = MEMADR;
                    OP_DP:   state_nxt = funct[5] ? EXECI : EXECR;
                    OP_BR:   state_nxt = BRANCH;
                    default: state_nxt = FETCH;
                endcase
            end
            MEMADR: begin
                state_nxt = funct[0] ? MEMRD : MEMWR;
                alu_src_b = 2'b01;
            end
            MEMRD: begin
                state_nxt = MEMWB;
                adr_src   = 1'b1;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
            end
            MEMWR: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
            end
            EXECR: begin
                state_nxt = ALUWB;
                alu_op    = 1'b1;
            end
            EXECI: begin
                state_nxt = ALUWB;
                alu_src_b = 2'b01;
                alu_op    = 1'b1;
            end
            ALUWB: begin
                reg_w = ~is_cmp;
            end
            BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                branch     = 1'b1;
            end
            default: state_nxt = FETCH;
        endcase
    end

    assign flag_load = ((state == EXECR) || (state == EXECI)) && cond_ex && (funct[0] || is_cmp);

    cond_unit u_cond (
        .clk      (clk),
        .reset_n  (reset_n),
        .Cond     (cond),
        .ALUFlags (ALUFlags),
        .FlagLoad (flag_load),
        .CondEx   (cond_ex)
    );

    assign IRWrite    = ir_write;
    assign AdrSrc     = adr_src;
    assign ALUSrcA    = alu_src_a;
    assign ALUSrcB    = alu_src_b;
    assign ResultSrc  = result_src;
    assign ImmSrc     = op;
    assign RegSrc     = {op == OP_MEM, op == OP_BR};
    assign ALUControl = alu_op ? alu_decode(funct[4:1], is_cmp) : ALU_ADD;
    assign RegWrite   = reg_w & cond_ex;
    assign MemWrite   = mem_w & cond_ex;
    assign PCWrite    = next_pc | (branch & cond_ex) | (reg_w & cond_ex & (rd == 4'hF));

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: directed instruction sequences with hand-derived per-cycle outputs.
module tb_mc_control;
    import mc_pkg::*;

`ifdef MC_CONTROL_CMP_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:12] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0]  RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

    mc_control dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .RegSrc     (RegSrc),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl)
    );

    always #5 clk = ~clk;

    // en  = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA}
    // sel = {RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl}
    typedef struct {
        string     name;
        mc_state_t st;
        logic [5:0] en;
        logic [9:0] sel;
        logic [3:0] fl;
    } exp_t;

    localparam logic [5:0] EN_F = 6'b100101;
    localparam logic [5:0] EN_D = 6'b000001;
    localparam logic [5:0] EN_0 = 6'b000000;
    localparam logic [9:0] S00  = 10'b00_10_10_00_00;
    localparam logic [9:0] S01  = 10'b10_10_10_01_00;
    localparam logic [9:0] S10  = 10'b01_10_10_10_00;
    localparam logic [9:0] S11  = 10'b00_10_10_11_00;
    localparam logic [9:0] SZ   = 10'b00_00_00_00_00;

    exp_t sb[$];
    exp_t m_e;
    logic [5:0] act_en;
    logic [9:0] act_sel;
    int n_vec = 0;
    int n_bad = 0;

    task automatic step(input string name, input logic [19:0] ins, input logic [3:0] af,
                        input logic rst, input mc_state_t st, input logic [5:0] en,
                        input logic [9:0] sel, input logic [3:0] fl);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n  = rst;
        Instr    = ins;
        ALUFlags = af;
        e.name = name;
        e.st   = st;
        e.en   = en;
        e.sel  = sel;
        e.fl   = fl;
        sb.push_back(e);
    endtask

    // Monitor: checks every queued expectation on the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            m_e     = sb.pop_front();
            act_en  = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA};
            act_sel = {RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl};
            n_vec++;
            if (dut.state !== m_e.st || act_en !== m_e.en || act_sel !== m_e.sel
                || dut.u_cond.flags !== m_e.fl) begin
                n_bad++;
                $display("FAIL %s: got state=%0d en=%b sel=%b flags=%b, want state=%0d en=%b sel=%b flags=%b",
                         m_e.name, dut.state, act_en, act_sel, dut.u_cond.flags,
                         m_e.st, m_e.en, m_e.sel, m_e.fl);
            end
        end
    end

    logic [3:0] fc;

    initial begin
        reset_n  = 1'b1;
        Instr    = '0;
        ALUFlags = '0;
        #1 reset_n = 1'b0;
        fc = CMP ? 4'b1000 : 4'b0100;

        step("reset0",      20'h00000, 4'b0000, 1'b0, FETCH,  EN_F, S00, 4'b0000);
        step("reset1",      20'h00000, 4'b0000, 1'b0, FETCH,  EN_F, S00, 4'b0000);

        // LDR
        step("ldr_fetch",   20'hE5902, 4'b0000, 1'b1, FETCH,  EN_F,      S01, 4'b0000);
        step("ldr_decode",  20'hE5902, 4'b0000, 1'b1, DECODE, EN_D,      S01, 4'b0000);
        step("ldr_memadr",  20'hE5902, 4'b0000, 1'b1, MEMADR, EN_0,      10'b10_01_00_01_00, 4'b0000);
        step("ldr_memrd",   20'hE5902, 4'b0000, 1'b1, MEMRD,  6'b000010, 10'b10_00_00_01_00, 4'b0000);
        step("ldr_memwb",   20'hE5902, 4'b0000, 1'b1, MEMWB,  6'b001000, 10'b10_00_01_01_00, 4'b0000);

        // ADDS sets Z
        step("adds_fetch",  20'hE0901, 4'b0100, 1'b1, FETCH,  EN_F,      S00, 4'b0000);
        step("adds_decode", 20'hE0901, 4'b0100, 1'b1, DECODE, EN_D,      S00, 4'b0000);
        step("adds_execr",  20'hE0901, 4'b0100, 1'b1, EXECR,  EN_0,      SZ,  4'b0000);
        step("adds_aluwb",  20'hE0901, 4'b0100, 1'b1, ALUWB,  6'b001000, SZ,  4'b0100);

        // BEQ taken
        step("beq_fetch",   20'h0A000, 4'b0000, 1'b1, FETCH,  EN_F,      S10, 4'b0100);
        step("beq_decode",  20'h0A000, 4'b0000, 1'b1, DECODE, EN_D,      S10, 4'b0100);
        step("beq_branch",  20'h0A000, 4'b0000, 1'b1, BRANCH, 6'b100000, 10'b01_01_10_10_00, 4'b0100);

        // ADDNE to PC with Z=1: no writes
        step("addne_fetch", 20'h1080F, 4'b1111, 1'b1, FETCH,  EN_F, S00, 4'b0100);
        step("addne_dec",   20'h1080F, 4'b1111, 1'b1, DECODE, EN_D, S00, 4'b0100);
        step("addne_execr", 20'h1080F, 4'b1111, 1'b1, EXECR,  EN_0, SZ,  4'b0100);
        step("addne_aluwb", 20'h1080F, 4'b1111, 1'b1, ALUWB,  EN_0, SZ,  4'b0100);

        // ADD writing R15 updates PC
        step("addpc_fetch", 20'hE080F, 4'b0000, 1'b1, FETCH,  EN_F,      S00, 4'b0100);
        step("addpc_dec",   20'hE080F, 4'b0000, 1'b1, DECODE, EN_D,      S00, 4'b0100);
        step("addpc_execr", 20'hE080F, 4'b0000, 1'b1, EXECR,  EN_0,      SZ,  4'b0100);
        step("addpc_aluwb", 20'hE080F, 4'b0000, 1'b1, ALUWB,  6'b101000, SZ,  4'b0100);

        // STR
        step("str_fetch",   20'hE5800, 4'b0000, 1'b1, FETCH,  EN_F,      S01, 4'b0100);
        step("str_decode",  20'hE5800, 4'b0000, 1'b1, DECODE, EN_D,      S01, 4'b0100);
        step("str_memadr",  20'hE5800, 4'b0000, 1'b1, MEMADR, EN_0,      10'b10_01_00_01_00, 4'b0100);
        step("str_memwr",   20'hE5800, 4'b0000, 1'b1, MEMWR,  6'b010010, 10'b10_00_00_01_00, 4'b0100);

        // Undefined Op=11 returns straight to FETCH
        step("und_fetch",   20'hEC000, 4'b1111, 1'b1, FETCH,  EN_F, S11, 4'b0100);
        step("und_decode",  20'hEC000, 4'b1111, 1'b1, DECODE, EN_D, S11, 4'b0100);

        // SUBS immediate
        step("subs_fetch",  20'hE2503, 4'b0010, 1'b1, FETCH,  EN_F,      S00, 4'b0100);
        step("subs_decode", 20'hE2503, 4'b0010, 1'b1, DECODE, EN_D,      S00, 4'b0100);
        step("subs_execi",  20'hE2503, 4'b0010, 1'b1, EXECI,  EN_0,      10'b00_01_00_00_01, 4'b0100);
        step("subs_aluwb",  20'hE2503, 4'b0010, 1'b1, ALUWB,  6'b001000, SZ,  4'b0010);

        // ORR without S leaves flags
        step("orr_fetch",   20'hE1804, 4'b1111, 1'b1, FETCH,  EN_F,      S00, 4'b0010);
        step("orr_decode",  20'hE1804, 4'b1111, 1'b1, DECODE, EN_D,      S00, 4'b0010);
        step("orr_execr",   20'hE1804, 4'b1111, 1'b1, EXECR,  EN_0,      10'b00_00_00_00_11, 4'b0010);
        step("orr_aluwb",   20'hE1804, 4'b1111, 1'b1, ALUWB,  6'b001000, SZ,  4'b0010);

        // AND
        step("and_fetch",   20'hE0005, 4'b1111, 1'b1, FETCH,  EN_F,      S00, 4'b0010);
        step("and_decode",  20'hE0005, 4'b1111, 1'b1, DECODE, EN_D,      S00, 4'b0010);
        step("and_execr",   20'hE0005, 4'b1111, 1'b1, EXECR,  EN_0,      10'b00_00_00_00_10, 4'b0010);
        step("and_aluwb",   20'hE0005, 4'b1111, 1'b1, ALUWB,  6'b001000, SZ,  4'b0010);

        // CMP (S set) of equal operands
        step("cmps_fetch",  20'hE1500, 4'b0100, 1'b1, FETCH,  EN_F, S00, 4'b0010);
        step("cmps_decode", 20'hE1500, 4'b0100, 1'b1, DECODE, EN_D, S00, 4'b0010);
        step("cmps_execr",  20'hE1500, 4'b0100, 1'b1, EXECR,  EN_0,
             CMP ? 10'b00_00_00_00_01 : SZ, 4'b0010);
        step("cmps_aluwb",  20'hE1500, 4'b0100, 1'b1, ALUWB,
             CMP ? EN_0 : 6'b001000, SZ, 4'b0100);

        // CMP encoding without S: flags only written when CMP is enabled
        step("cmp_fetch",   20'hE1400, 4'b1000, 1'b1, FETCH,  EN_F, S00, 4'b0100);
        step("cmp_decode",  20'hE1400, 4'b1000, 1'b1, DECODE, EN_D, S00, 4'b0100);
        step("cmp_execr",   20'hE1400, 4'b1000, 1'b1, EXECR,  EN_0,
             CMP ? 10'b00_00_00_00_01 : SZ, 4'b0100);
        step("cmp_aluwb",   20'hE1400, 4'b1000, 1'b1, ALUWB,
             CMP ? EN_0 : 6'b001000, SZ, fc);

        // Reset asserted in EXECR of an ADDS, then a clean restart
        step("rst_fetch",   20'hE0901, 4'b1001, 1'b1, FETCH,  EN_F,      S00, fc);
        step("rst_decode",  20'hE0901, 4'b1001, 1'b1, DECODE, EN_D,      S00, fc);
        step("rst_midexec", 20'hE0901, 4'b1001, 1'b0, FETCH,  EN_F,      S00, 4'b0000);
        step("rst_held",    20'hE0901, 4'b1001, 1'b0, FETCH,  EN_F,      S00, 4'b0000);
        step("rst_release", 20'hE0901, 4'b1001, 1'b1, FETCH,  EN_F,      S00, 4'b0000);
        step("post_decode", 20'hE0901, 4'b1001, 1'b1, DECODE, EN_D,      S00, 4'b0000);
        step("post_execr",  20'hE0901, 4'b1001, 1'b1, EXECR,  EN_0,      SZ,  4'b0000);
        step("post_aluwb",  20'hE0901, 4'b1001, 1'b1, ALUWB,  6'b001000, SZ,  4'b1001);

        @(posedge clk);
        @(negedge clk);
        #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
